// File: rtl/float_add_arbiter.sv
// float_add_arbiter: round-robin sharing of one pipelined float adder among NUM_CLIENTS requesters.
// Optional perf counters (perf_issued, perf_stall) exist only when FLOAT_ADD_ARB_PERF_EN is defined.
module float_add_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int FLOAT_WIDTH = 32,
    parameter int ADD_LATENCY = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CLIENTS-1:0]             cli_req,
    input  logic [NUM_CLIENTS*FLOAT_WIDTH-1:0] cli_a,
    input  logic [NUM_CLIENTS*FLOAT_WIDTH-1:0] cli_b,
    output logic [NUM_CLIENTS-1:0]             cli_gnt,
    output logic [NUM_CLIENTS-1:0]             cli_ack,
    output logic [FLOAT_WIDTH-1:0]             cli_out,
    output logic                               add_req,
    output logic [FLOAT_WIDTH-1:0]             add_a,
    output logic [FLOAT_WIDTH-1:0]             add_b,
    input  logic                               add_ack,
    input  logic [FLOAT_WIDTH-1:0]             add_out,
    output logic                               err
`ifdef FLOAT_ADD_ARB_PERF_EN
    ,
    output logic [31:0]                        perf_issued,
    output logic [31:0]                        perf_stall
`endif
);
    localparam int ID_W = $clog2(NUM_CLIENTS);
    localparam logic [ID_W:0]        NUM_CLIENTS_W = (ID_W + 1)'(NUM_CLIENTS);
    localparam logic [ID_W-1:0]      ONE_ID        = ID_W'(32'd1);
    localparam logic [NUM_CLIENTS-1:0] ONE_CLI     = NUM_CLIENTS'(32'd1);

    // base + off modulo NUM_CLIENTS; both operands are already < NUM_CLIENTS
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input logic [ID_W-1:0] off);
        logic [ID_W:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= NUM_CLIENTS_W) begin
            sum = sum - NUM_CLIENTS_W;
        end else begin
            sum = sum;
        end
        return sum[ID_W-1:0];
    endfunction

    function automatic logic [NUM_CLIENTS-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        return ONE_CLI << id;
    endfunction

    logic [NUM_CLIENTS-1:0]           pending_r;
    logic [ID_W-1:0]                  rr_r;
    logic [ID_W-1:0]                  issue_id_r;
    logic [ADD_LATENCY-1:0]           tag_vld_r;
    logic [ADD_LATENCY-1:0][ID_W-1:0] tag_id_r;

    logic [NUM_CLIENTS-1:0]   elig_s;
    logic [2*NUM_CLIENTS-1:0] elig_dbl_s;
    logic [NUM_CLIENTS-1:0]   elig_rot_s;
    logic [ID_W-1:0]          off_s;
    logic [ID_W-1:0]          win_id_s;
    logic                     win_vld_s;
    logic [NUM_CLIENTS-1:0]   gnt_set_s;
    logic [FLOAT_WIDTH-1:0]   win_a_s;
    logic [FLOAT_WIDTH-1:0]   win_b_s;
    logic                     ret_vld_s;
    logic [ID_W-1:0]          ret_id_s;
    logic [NUM_CLIENTS-1:0]   ack_clr_s;

    // round-robin pick: rotate so the rr pointer lands on bit 0, then take the lowest set bit
    always_comb begin
        elig_s     = cli_req & ~pending_r;
        elig_dbl_s = {elig_s, elig_s} >> rr_r;
        elig_rot_s = elig_dbl_s[NUM_CLIENTS-1:0];
        win_vld_s  = |elig_s;
        off_s      = '0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            if (elig_rot_s[k]) begin
                off_s = ID_W'(k);
            end else begin
                off_s = off_s;
            end
        end
        win_id_s  = wrap_add(rr_r, off_s);
        gnt_set_s = win_vld_s ? id_to_onehot(win_id_s) : '0;
    end

    // operand mux for the winning client
    always_comb begin
        win_a_s = '0;
        win_b_s = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (win_id_s == ID_W'(k)) begin
                win_a_s = cli_a[k*FLOAT_WIDTH +: FLOAT_WIDTH];
                win_b_s = cli_b[k*FLOAT_WIDTH +: FLOAT_WIDTH];
            end else begin
                win_a_s = win_a_s;
                win_b_s = win_b_s;
            end
        end
    end

    // oldest tag, expected to line up with add_ack this cycle
    always_comb begin
        ret_vld_s = tag_vld_r[ADD_LATENCY-1];
        ret_id_s  = tag_id_r[ADD_LATENCY-1];
        ack_clr_s = ret_vld_s ? id_to_onehot(ret_id_s) : '0;
    end

    // issue stage: grant pulse, operands to the adder, rr pointer advance
    always_ff @(posedge clk) begin
        if (rst) begin
            cli_gnt    <= '0;
            add_req    <= 1'b0;
            add_a      <= '0;
            add_b      <= '0;
            issue_id_r <= '0;
            rr_r       <= '0;
        end else begin
            cli_gnt <= gnt_set_s;
            add_req <= win_vld_s;
            if (win_vld_s) begin
                add_a      <= win_a_s;
                add_b      <= win_b_s;
                issue_id_r <= win_id_s;
                rr_r       <= wrap_add(win_id_s, ONE_ID);
            end else begin
                add_a      <= add_a;
                add_b      <= add_b;
                issue_id_r <= issue_id_r;
                rr_r       <= rr_r;
            end
        end
    end

    // owner tag shift register, entered in the same cycle add_req is presented
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_r <= '0;
            tag_id_r  <= '0;
        end else begin
            tag_vld_r[0] <= add_req;
            tag_id_r[0]  <= issue_id_r;
            for (int k = 1; k < ADD_LATENCY; k++) begin
                tag_vld_r[k] <= tag_vld_r[k-1];
                tag_id_r[k]  <= tag_id_r[k-1];
            end
        end
    end

    // return path: ack routing, pending bookkeeping, sticky handshake error
    always_ff @(posedge clk) begin
        if (rst) begin
            cli_ack   <= '0;
            cli_out   <= '0;
            pending_r <= '0;
            err       <= 1'b0;
        end else begin
            // a mismatched tag still frees its client so it cannot deadlock
            pending_r <= (pending_r | gnt_set_s) & ~ack_clr_s;
            if (ret_vld_s && add_ack) begin
                cli_ack <= ack_clr_s;
                cli_out <= add_out;
            end else begin
                cli_ack <= '0;
                cli_out <= cli_out;
            end
            if (ret_vld_s != add_ack) begin
                err <= 1'b1;
            end else begin
                err <= err;
            end
        end
    end

`ifdef FLOAT_ADD_ARB_PERF_EN
    logic multi_elig_s;
    assign multi_elig_s = |(elig_s & (elig_s - ONE_CLI));

    // issue and contention counters, free-running with natural wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued <= 32'd0;
            perf_stall  <= 32'd0;
        end else begin
            perf_issued <= add_req ? perf_issued + 32'd1 : perf_issued;
            perf_stall  <= multi_elig_s ? perf_stall + 32'd1 : perf_stall;
        end
    end
`endif

endmodule

// File: tb/tb_float_add_arbiter.sv
// Self-checking bench for float_add_arbiter: bench-side adder, queue-based reference model,
// directed scenarios plus randomized client traffic.
module tb_float_add_arbiter;
    localparam int NC  = 4;
    localparam int FW  = 32;
    localparam int LAT = 4;
    localparam logic [NC-1:0] ONE_C = NC'(32'd1);

    logic clk = 1'b0;
    logic rst;
    logic [NC-1:0]    cli_req;
    logic [NC*FW-1:0] cli_a;
    logic [NC*FW-1:0] cli_b;
    logic [NC-1:0]    cli_gnt;
    logic [NC-1:0]    cli_ack;
    logic [FW-1:0]    cli_out;
    logic             add_req;
    logic [FW-1:0]    add_a;
    logic [FW-1:0]    add_b;
    logic             add_ack;
    logic [FW-1:0]    add_out;
    logic             err;
`ifdef FLOAT_ADD_ARB_PERF_EN
    logic [31:0]      perf_issued;
    logic [31:0]      perf_stall;
`endif

    float_add_arbiter #(.NUM_CLIENTS(NC), .FLOAT_WIDTH(FW), .ADD_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .cli_req(cli_req), .cli_a(cli_a), .cli_b(cli_b),
        .cli_gnt(cli_gnt), .cli_ack(cli_ack), .cli_out(cli_out),
        .add_req(add_req), .add_a(add_a), .add_b(add_b), .add_ack(add_ack), .add_out(add_out),
        .err(err)
`ifdef FLOAT_ADD_ARB_PERF_EN
        , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        int          due;
        logic [31:0] res;
    } op_t;

    op_t         flight_q[$];
    logic [NC-1:0] m_pend, exp_gnt, exp_ack;
    logic        exp_add_req, exp_err;
    logic [FW-1:0] exp_out, exp_a, exp_b;
    int          m_rr;
    logic [31:0] m_issued, m_stall;
    logic        ad_v [0:LAT+1];
    logic [FW-1:0] ad_r [0:LAT+1];
    bit          late_mode;
    int          edge_n;
    logic [FW-1:0] job_a [NC][64];
    logic [FW-1:0] job_b [NC][64];
    int          head [NC];
    int          tail [NC];
    int          gnt_edge [NC], ack_edge [NC], ack_first [NC], req_edge [NC];
    int          gnt_cnt [NC], ack_cnt [NC];
    logic [FW-1:0] ack_val [NC];
    int          n_chk, n_pass;

    // IEEE single -> real (normals and zero only)
    function automatic real f2r(input logic [31:0] f);
        int  e;
        real r;
        e = int'(f[30:23]);
        if (e == 0) return 0.0;
        r = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** real'(e - 127));
        return f[31] ? -r : r;
    endfunction

    // real -> IEEE single, round to nearest even
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] de;
        logic [30:0] mag;
        logic [28:0] low;
        d  = $realtobits(r);
        de = d[62:52];
        if (de == 11'd0) return {d[63], 31'd0};
        mag = {8'(int'(de) - 896), d[51:29]};
        low = d[28:0];
        if (low > 29'h1000_0000 || (low == 29'h1000_0000 && mag[0])) mag = mag + 31'd1;
        return {d[63], mag};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] rand_f();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
    endfunction

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s @edge %0d: got %h want %h", tag, edge_n, got, want);
    endtask

    task automatic model_clear();
        flight_q.delete();
        m_pend = '0; exp_gnt = '0; exp_ack = '0; exp_add_req = 1'b0; exp_err = 1'b0;
        exp_out = '0; exp_a = '0; exp_b = '0; m_rr = 0; m_issued = 32'd0; m_stall = 32'd0;
        for (int j = 0; j <= LAT + 1; j++) begin ad_v[j] = 1'b0; ad_r[j] = '0; end
    endtask

    task automatic clear_marks();
        for (int i = 0; i < NC; i++) begin
            gnt_edge[i] = -1; ack_edge[i] = -1; ack_first[i] = -1; req_edge[i] = -1;
            gnt_cnt[i] = 0; ack_cnt[i] = 0; head[i] = 0; tail[i] = 0; ack_val[i] = '0;
        end
    endtask

    task automatic push(input int c, input logic [31:0] a, input logic [31:0] b);
        job_a[c][tail[c]] = a;
        job_b[c][tail[c]] = b;
        tail[c]++;
    endtask

    function automatic bit idle();
        for (int i = 0; i < NC; i++) if (head[i] != tail[i]) return 1'b0;
        return flight_q.size() == 0;
    endfunction

    // one clock: observe+check, drive clients and adder, advance model, wait for next negedge
    task automatic cycle();
        logic [NC-1:0] elig;
        op_t op;
        int  e, c;
        bit  found;
        for (int i = 0; i < NC; i++) begin
            if (cli_gnt[i]) begin
                gnt_edge[i] = edge_n; gnt_cnt[i]++;
                if (head[i] < tail[i]) head[i]++;
            end
            if (cli_ack[i]) begin
                ack_edge[i] = edge_n; ack_cnt[i]++; ack_val[i] = cli_out;
                if (ack_first[i] < 0) ack_first[i] = edge_n;
            end
        end
        check_value("cli_gnt", 32'(cli_gnt), 32'(exp_gnt));
        check_value("cli_ack", 32'(cli_ack), 32'(exp_ack));
        check_value("cli_out", cli_out, exp_out);
        check_value("add_req", 32'(add_req), 32'(exp_add_req));
        check_value("add_a", add_a, exp_a);
        check_value("add_b", add_b, exp_b);
        check_value("err", 32'(err), 32'(exp_err));
`ifdef FLOAT_ADD_ARB_PERF_EN
        check_value("perf_issued", perf_issued, m_issued);
        check_value("perf_stall", perf_stall, m_stall);
`endif
        for (int i = 0; i < NC; i++) begin
            if (!rst && head[i] < tail[i]) begin
                if (!cli_req[i]) req_edge[i] = edge_n + 1;
                cli_req[i] = 1'b1;
                cli_a[i*FW +: FW] = job_a[i][head[i]];
                cli_b[i*FW +: FW] = job_b[i][head[i]];
            end else begin
                cli_req[i] = 1'b0;
            end
        end
        for (int j = LAT + 1; j > 0; j--) begin ad_v[j] = ad_v[j-1]; ad_r[j] = ad_r[j-1]; end
        ad_v[0] = add_req;
        ad_r[0] = fadd(add_a, add_b);
        if (rst) begin
            for (int j = 0; j <= LAT + 1; j++) ad_v[j] = 1'b0;
            add_ack = 1'b0;
            add_out = '0;
        end else begin
            add_ack = late_mode ? ad_v[LAT+1] : ad_v[LAT];
            add_out = add_ack ? (late_mode ? ad_r[LAT+1] : ad_r[LAT]) : FW'($urandom);
        end
        e = edge_n + 1;
        if (rst) begin
            model_clear();
        end else begin
            elig = cli_req & ~m_pend;
            if (exp_add_req) m_issued++;
            if ($countones(elig) > 1) m_stall++;
            exp_gnt = '0; exp_ack = '0; exp_add_req = 1'b0;
            if (flight_q.size() > 0 && flight_q[0].due == e) begin
                op = flight_q.pop_front();
                m_pend = m_pend & ~(ONE_C << op.id);
                if (late_mode) exp_err = 1'b1;
                else begin exp_ack = ONE_C << op.id; exp_out = op.res; end
            end
            found = 1'b0;
            for (int k = 0; k < NC; k++) begin
                c = (m_rr + k) % NC;
                if (!found && elig[c]) begin
                    found = 1'b1;
                    exp_gnt = ONE_C << c;
                    exp_add_req = 1'b1;
                    exp_a = cli_a[c*FW +: FW];
                    exp_b = cli_b[c*FW +: FW];
                    m_pend = m_pend | (ONE_C << c);
                    m_rr = (c + 1) % NC;
                    op.id = c; op.due = e + 1 + LAT; op.res = fadd(exp_a, exp_b);
                    flight_q.push_back(op);
                end
            end
        end
        edge_n++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while (n < budget && !idle()) begin cycle(); n++; end
        check_value("drain", 32'(idle()), 32'd1);
        cycle();
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NC; i++) head[i] = tail[i];
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int tot;
        rst = 1'b1; cli_req = '0; cli_a = '0; cli_b = '0; add_ack = 1'b0; add_out = '0;
        late_mode = 1'b0; edge_n = 0; n_chk = 0; n_pass = 0;
        model_clear();
        clear_marks();
        @(posedge clk); @(negedge clk); edge_n = 1;
        cycle(); cycle();
        rst = 1'b0;

        // single op latency and result
        clear_marks();
        push(0, 32'h3F80_0000, 32'h3F80_0000);
        run_idle(40);
        check_value("t1_latency", 32'(ack_edge[0] + 1 - req_edge[0]), 32'd6);
        check_value("t1_out", ack_val[0], 32'h4000_0000);
        check_value("t1_err", 32'(err), 32'd0);

        // all four clients at once
        do_reset();
        clear_marks();
        push(0, 32'h3F80_0000, 32'h3F80_0000);
        push(1, 32'h4000_0000, 32'h4040_0000);
        push(2, 32'hC0A3_3333, 32'hC04C_CCCD);
        push(3, 32'h3FC0_0000, 32'hBFC0_0000);
        run_idle(40);
        for (int i = 1; i < NC; i++) begin
            check_value("t2_gnt_order", 32'(gnt_edge[i] - gnt_edge[0]), 32'(i));
            check_value("t2_ack_order", 32'(ack_edge[i] - ack_edge[0]), 32'(i));
        end
        check_value("t2_out0", ack_val[0], 32'h4000_0000);
        check_value("t2_out1", ack_val[1], 32'h40A0_0000);
        check_value("t2_out2", ack_val[2], fadd(32'hC0A3_3333, 32'hC04C_CCCD));
        check_value("t2_out3", ack_val[3], 32'h0000_0000);
`ifdef FLOAT_ADD_ARB_PERF_EN
        check_value("t2_perf_issued", perf_issued, 32'd4);
`endif

        // streaming client 2, late single request from client 1
        clear_marks();
        for (int j = 0; j < 6; j++) push(2, rand_f(), rand_f());
        cycle(); cycle(); cycle();
        push(1, rand_f(), rand_f());
        run_idle(100);
        check_value("t3_c1_wait", 32'(gnt_edge[1] >= req_edge[1] && gnt_edge[1] + 1 - req_edge[1] <= NC), 32'd1);
        check_value("t3_c2_count", 32'(ack_cnt[2]), 32'd6);

        // request held while pending
        clear_marks();
        push(1, rand_f(), rand_f());
        push(1, rand_f(), rand_f());
        run_idle(60);
        check_value("t4_gnt_count", 32'(gnt_cnt[1]), 32'd2);
        check_value("t4_regrant", 32'(gnt_edge[1]), 32'(ack_first[1] + 1));

        // reset with three ops in flight
        clear_marks();
        push(0, rand_f(), rand_f());
        push(1, rand_f(), rand_f());
        push(2, rand_f(), rand_f());
        cycle(); cycle(); cycle();
        do_reset();
        check_value("t5_outs_zero", {28'(cli_gnt), 28'(cli_ack)} == 56'd0 ? 32'(add_req | err) : 32'd1, 32'd0);
        check_value("t5_out_zero", cli_out | add_a | add_b, 32'd0);
        clear_marks();
        for (int j = 0; j < 10; j++) cycle();
        tot = 0;
        for (int i = 0; i < NC; i++) tot += ack_cnt[i];
        check_value("t5_no_ack", 32'(tot), 32'd0);
        push(3, 32'h3F80_0000, 32'h4000_0000);
        run_idle(40);
        check_value("t5_latency", 32'(ack_edge[3] + 1 - req_edge[3]), 32'd6);
        check_value("t5_out", ack_val[3], 32'h4040_0000);

        // adder acks one cycle late
        clear_marks();
        late_mode = 1'b1;
        push(0, rand_f(), rand_f());
        run_idle(40);
        cycle(); cycle(); cycle();
        check_value("t6_err_sticky", 32'(err), 32'd1);
        check_value("t6_no_ack", 32'(ack_cnt[0]), 32'd0);
        late_mode = 1'b0;
        do_reset();
        check_value("t6_err_cleared", 32'(err), 32'd0);

        // randomized traffic
        clear_marks();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NC; i++) begin
                if (tail[i] - head[i] < 2 && tail[i] < 60 && $urandom_range(0, 3) == 0)
                    push(i, rand_f(), rand_f());
            end
            cycle();
        end
        run_idle(200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
